// File: rtl/bus_arbiter.sv
// Two-master arbiter and access sequencer in front of memory_bus.
// Fixed CPU (master 0) priority, with a starvation guard that forces a master 1 grant.
module bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned HALT_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [23:0] m0_address,
    input  logic        m0_write,
    input  logic [7:0]  m0_wdata,
    output logic [7:0]  m0_rdata,
    output logic        m0_done,
    output logic        m0_error,
    input  logic        m1_req,
    input  logic [23:0] m1_address,
    input  logic        m1_write,
    input  logic [7:0]  m1_wdata,
    output logic [7:0]  m1_rdata,
    output logic        m1_done,
    output logic        m1_error,
    output logic [23:0] bus_address,
    output logic [7:0]  bus_data_in,
    input  logic [7:0]  bus_data_out,
    output logic        bus_enable,
    output logic        write_enable,
    input  logic        bus_halt
);

    localparam logic [3:0]  L_STARVE    = 4'(STARVE_LIMIT);
    localparam logic [15:0] L_HALT_LAST = 16'(HALT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic [3:0]  r_streak;
    logic [15:0] r_halt_cnt;

    logic        w_any_req;
    logic        w_grant_m1;
    logic [23:0] w_sel_address;
    logic [7:0]  w_sel_wdata;
    logic        w_sel_write;

    // Master 1 wins when the CPU is idle or has been served STARVE_LIMIT times in a row.
    assign w_any_req     = m0_req | m1_req;
    assign w_grant_m1    = m1_req & (~m0_req | (r_streak == L_STARVE));
    assign w_sel_address = w_grant_m1 ? m1_address : m0_address;
    assign w_sel_wdata   = w_grant_m1 ? m1_wdata   : m0_wdata;
    assign w_sel_write   = w_grant_m1 ? m1_write   : m0_write;

    // Arbitration FSM with registered bus and completion outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_streak     <= 4'd0;
            r_halt_cnt   <= 16'd0;
            bus_address  <= 24'd0;
            bus_data_in  <= 8'd0;
            bus_enable   <= 1'b0;
            write_enable <= 1'b0;
            m0_rdata     <= 8'd0;
            m1_rdata     <= 8'd0;
            m0_done      <= 1'b0;
            m1_done      <= 1'b0;
            m0_error     <= 1'b0;
            m1_error     <= 1'b0;
        end else begin
            m0_done  <= 1'b0;
            m1_done  <= 1'b0;
            m0_error <= 1'b0;
            m1_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_grant_m1;
                        bus_address  <= w_sel_address;
                        bus_data_in  <= w_sel_wdata;
                        write_enable <= w_sel_write;
                        bus_enable   <= 1'b1;
                        r_halt_cnt   <= 16'd0;
                        r_state      <= ST_ACCESS;
                        if (!w_grant_m1 && m1_req) begin
                            r_streak <= (r_streak >= L_STARVE) ? L_STARVE : r_streak + 4'd1;
                        end else begin
                            r_streak <= 4'd0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!bus_halt) begin
                        if (!write_enable) begin
                            if (r_owner) begin
                                m1_rdata <= bus_data_out;
                            end else begin
                                m0_rdata <= bus_data_out;
                            end
                        end else begin
                            r_halt_cnt <= r_halt_cnt;
                        end
                        bus_enable   <= 1'b0;
                        write_enable <= 1'b0;
                        m0_done      <= ~r_owner;
                        m1_done      <= r_owner;
                        r_state      <= ST_DONE;
                    end else if (r_halt_cnt == L_HALT_LAST) begin
                        // Timed out: read data reads back as all ones.
                        if (!write_enable) begin
                            if (r_owner) begin
                                m1_rdata <= 8'hFF;
                            end else begin
                                m0_rdata <= 8'hFF;
                            end
                        end else begin
                            r_halt_cnt <= r_halt_cnt;
                        end
                        bus_enable   <= 1'b0;
                        write_enable <= 1'b0;
                        m0_done      <= ~r_owner;
                        m1_done      <= r_owner;
                        m0_error     <= ~r_owner;
                        m1_error     <= r_owner;
                        r_state      <= ST_DONE;
                    end else begin
                        r_halt_cnt <= r_halt_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    bus_enable   <= 1'b0;
                    write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed test-plan steps, then randomized
// traffic checked against a transaction-level reference model.
module tb_bus_arbiter;

    localparam int LIM = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [23:0] m0_address, m1_address;
    logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_done, m0_error, m1_done, m1_error;
    logic [23:0] bus_address;
    logic [7:0]  bus_data_in, bus_data_out;
    logic        bus_enable, write_enable, bus_halt;

    int checks   = 0;
    int failures = 0;

    // Reference model state: pending requests per master, expected rdata, CPU streak.
    logic        p_req  [2];
    logic [23:0] p_addr [2];
    logic        p_wr   [2];
    logic [7:0]  p_wd   [2];
    logic [7:0]  exp_rd [2];
    int          streak_m;

    bus_arbiter #(.STARVE_LIMIT(LIM), .HALT_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_address(m0_address), .m0_write(m0_write), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_error(m0_error),
        .m1_req(m1_req), .m1_address(m1_address), .m1_write(m1_write), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_error(m1_error),
        .bus_address(bus_address), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .bus_enable(bus_enable), .write_enable(write_enable), .bus_halt(bus_halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_reqs();
        m0_req = p_req[0]; m0_address = p_addr[0]; m0_write = p_wr[0]; m0_wdata = p_wd[0];
        m1_req = p_req[1]; m1_address = p_addr[1]; m1_write = p_wr[1]; m1_wdata = p_wd[1];
    endtask

    task automatic set_req(input int m, input logic [23:0] a, input logic w, input logic [7:0] d);
        p_req[m] = 1'b1; p_addr[m] = a; p_wr[m] = w; p_wd[m] = d;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            p_req[m] = 1'b0; p_addr[m] = 24'd0; p_wr[m] = 1'b0; p_wd[m] = 8'd0; exp_rd[m] = 8'd0;
        end
        streak_m = 0;
    endtask

    // One complete access; called at a falling edge with the DUT idle or in its done cycle.
    task automatic run_txn(input int h, input bit after_done, output int obs_w);
        int   w;
        int   nh;
        bit   tmo;
        logic [7:0] bdo;
        drive_reqs();
        if (after_done) begin
            @(posedge clk); @(negedge clk);
            chk("idle_no_grant", 32'(bus_enable), 32'd0);
        end
        w = (p_req[1] && (!p_req[0] || streak_m == LIM)) ? 1 : 0;
        if (w == 1 || !p_req[1]) streak_m = 0;
        else streak_m = (streak_m < LIM) ? streak_m + 1 : LIM;
        @(posedge clk); @(negedge clk);
        chk("grant_addr", 32'(bus_address), 32'(p_addr[w]));
        chk("grant_we", 32'(write_enable), 32'(p_wr[w]));
        if (p_wr[w]) chk("grant_wdata", 32'(bus_data_in), 32'(p_wd[w]));
        bdo = 8'($urandom);
        bus_data_out = bdo;
        tmo = (h >= TMO);
        nh  = tmo ? TMO : h;
        for (int i = 0; i < nh; i++) begin
            chk("access_en", 32'(bus_enable), 32'd1);
            chk("early_done", 32'({m1_done, m0_done}), 32'd0);
            bus_halt = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        if (!tmo) begin
            chk("access_en", 32'(bus_enable), 32'd1);
            chk("early_done", 32'({m1_done, m0_done}), 32'd0);
            bus_halt = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        bus_halt = 1'b0;
        if (!p_wr[w]) exp_rd[w] = tmo ? 8'hFF : bdo;
        chk("done_flags", 32'({m1_done, m0_done}), (w == 1) ? 32'd2 : 32'd1);
        chk("error_flags", 32'({m1_error, m0_error}), tmo ? ((w == 1) ? 32'd2 : 32'd1) : 32'd0);
        chk("m0_rdata", 32'(m0_rdata), 32'(exp_rd[0]));
        chk("m1_rdata", 32'(m1_rdata), 32'(exp_rd[1]));
        chk("done_bus_idle", 32'({bus_enable, write_enable}), 32'd0);
        obs_w = m1_done ? 1 : 0;
        p_req[w] = 1'b0;
    endtask

    task automatic rand_reqs();
        for (int m = 0; m < 2; m++) begin
            if (!p_req[m] && $urandom_range(0, 1) == 1)
                set_req(m, 24'($urandom), 1'($urandom), 8'($urandom));
        end
        if (!p_req[0] && !p_req[1])
            set_req(int'($urandom_range(0, 1)), 24'($urandom), 1'($urandom), 8'($urandom));
    endtask

    initial begin : stim
        int w;
        int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int h;

        reset = 1'b0; bus_halt = 1'b0; bus_data_out = 8'd0;
        model_reset();
        drive_reqs();
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(bus_address), 32'd0);
        chk("rst_data", 32'({bus_data_in, m0_rdata, m1_rdata}), 32'd0);
        chk("rst_flags", 32'({bus_enable, write_enable, m0_done, m1_done, m0_error, m1_error}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single read, halted read, write.
        set_req(0, 24'h008010, 1'b0, 8'h00);
        run_txn(0, 1'b0, w);
        set_req(1, 24'h010000, 1'b0, 8'h00);
        run_txn(7, 1'b1, w);
        set_req(0, 24'h008123, 1'b1, 8'hA7);
        run_txn(0, 1'b1, w);

        // Both masters requesting continuously.
        for (int k = 0; k < 10; k++) begin
            for (int m = 0; m < 2; m++)
                if (!p_req[m]) set_req(m, 24'($urandom), 1'b0, 8'h00);
            run_txn(0, 1'b1, w);
            chk("starve_order", 32'(w), 32'(exp_order[k]));
        end

        // Timeout, then a normal access.
        p_req[0] = 1'b0;
        set_req(1, 24'h020000, 1'b0, 8'h00);
        run_txn(TMO + 4, 1'b1, w);
        set_req(0, 24'h000004, 1'b0, 8'h00);
        run_txn(2, 1'b1, w);

        // Reset in the middle of a halted access.
        set_req(0, 24'h030000, 1'b0, 8'h00);
        drive_reqs();
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("pre_rst_en", 32'(bus_enable), 32'd1);
        bus_halt = 1'b1;
        @(posedge clk); @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_en", 32'(bus_enable), 32'd0);
        chk("rst_no_done", 32'({m0_done, m1_done, m0_error, m1_error}), 32'd0);
        bus_halt = 1'b0;
        model_reset();
        drive_reqs();
        @(negedge clk); @(negedge clk);
        chk("rst_held_done", 32'({m0_done, m1_done}), 32'd0);
        reset = 1'b1;
        set_req(0, 24'h008010, 1'b0, 8'h00);
        run_txn(0, 1'b0, w);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            rand_reqs();
            h = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(0, 3));
            run_txn(h, 1'b1, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and access sequencer in front of `memory_bus`. It shares the single 24-bit byte bus between the CPU (master 0) and a DMA/loader engine (master 1). It drives `bus_enable`, `write_enable`, address and write data, and holds an access open while `bus_halt` is high (SD fetch or h-blank wait). It returns read data with a one-cycle `done` pulse, and applies fixed CPU priority with a starvation guard for master 1.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive master-0 grants, taken while master 1 waits, before master 1 is forced the next grant (1..15).
- HALT_TIMEOUT, 4096: maximum `bus_halt` cycles per access before abort (16-bit counter).

Ports:
- clk  in  1  system clock, same domain as the CPU.
- reset  in  1  asynchronous, active-low reset. Same name as in the rest of the codebase, but this block's polarity is active-low.
- m0_req, m1_req  in  1  access request. Held with its fields until the matching done.
- m0_address, m1_address  in  24  byte address.
- m0_write, m1_write  in  1  1 = write, 0 = read.
- m0_wdata, m1_wdata  in  8  write data.
- m0_rdata, m1_rdata  out  8  read data. Valid in the done cycle and held until that master's next done.
- m0_done, m1_done  out  1  one-cycle completion pulse.
- m0_error, m1_error  out  1  one-cycle pulse with done when the access timed out.
- bus_address  out  24  to memory_bus address.
- bus_data_in  out  8  to memory_bus data_in.
- bus_data_out  in  8  from memory_bus data_out.
- bus_enable  out  1  to memory_bus.
- write_enable  out  1  to memory_bus.
- bus_halt  in  1  from memory_bus; 1 = access not finished.

## Operation
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE, grant rule:
  - If `m1_req && (!m0_req || streak == STARVE_LIMIT)`, grant master 1.
  - Else if `m0_req`, grant master 0.
  - On the grant edge, register the address, wdata and write flag into the bus outputs, set `bus_enable` = 1, set `write_enable` = write flag, and go to ACCESS.
- Streak counter, 4 bits:
  - Increments on a master-0 grant while `m1_req` = 1, saturating at STARVE_LIMIT.
  - Clears on a master-1 grant, or on a master-0 grant while `m1_req` = 0.
- ACCESS:
  - Bus outputs are held stable.
  - At each edge with `bus_halt` = 0: capture `bus_data_out` into the winner's rdata (reads only; writes leave rdata unchanged), drop `bus_enable` and `write_enable`, assert the winner's done, and go to DONE.
  - With `bus_halt` = 1: the halt counter increments.
  - When the halt counter reaches HALT_TIMEOUT: abort, drop the enables, set rdata = 8'hFF (reads), assert done and error, and go to DONE.
- DONE:
  - done/error are high for exactly this cycle and the bus is idle.
  - No grant is made in this cycle, which gives the requester one cycle to drop or change req.
  - Next state is IDLE.
- A req that drops mid-ACCESS does not abort the access; done still pulses.
- Masters' rdata registers are independent. A master-1 access never disturbs `m0_rdata`.

## Timing
- Reset (`reset` = 0, asynchronous):
  - State IDLE; streak and halt counter cleared.
  - All outputs 0: `bus_enable`, `write_enable`, `bus_address`, `bus_data_in`, rdata, done, error.
- Reset asserted mid-access: the bus drops immediately and no done is issued. After release, the arbiter is in IDLE.
- Latency without halt: req sampled at edge N.
  - `bus_enable` is high during cycle N+1.
  - done is high during cycle N+2.
  - A new grant is possible at the edge ending N+3.
  - Result: 3 cycles per access, 2 cycles req-to-done.
- Each `bus_halt` cycle adds exactly one cycle of latency.
- Simultaneous requests in IDLE resolve in the same cycle; there is no extra arbitration cycle.
- Write data must reach memory_bus while `bus_enable` and `write_enable` are high. Memory writes on raw_clk within the ACCESS cycle.

## Test plan
- Single read, no halt: m0_req=1 at 0x008010, `bus_data_out` = 0x5A -> `bus_enable` high for 1 cycle, `m0_done` 2 cycles after req, `m0_rdata` = 0x5A, `write_enable` stays 0.
- Halted read: m1 reads 0x010000 with `bus_halt` high 7 cycles, `bus_data_out` = 0x3C -> `bus_enable` high 8 cycles, `m1_done` at req+9, `m1_rdata` = 0x3C, `m1_error` = 0.
- Starvation: both masters request continuously with STARVE_LIMIT = 4 -> grant order m0,m0,m0,m0,m1,m0,m0,m0,m0,m1.
- Write: m0 writes 0xA7 to 0x008123 -> `bus_address` = 0x008123, `bus_data_in` = 0xA7, `write_enable` = `bus_enable` = 1 for one cycle, `m0_rdata` unchanged.
- Timeout: `bus_halt` held high with HALT_TIMEOUT = 16 -> done and error pulse after 16 halt cycles, rdata = 0xFF, next access proceeds normally.
- Reset mid-ACCESS: `reset` = 0 while `bus_halt` = 1 -> `bus_enable` drops asynchronously, no done; after release, a fresh m0 read completes in 2 cycles.
